// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester handshakes and the data-memory pins that
//   mem_arbiter sits between. The arbiter connects through the slave
//   modport; the requesters and the memory model sit on the master side.
//
//   Port 0 / port 1 (x = 0, 1):
//     px_req    request, held until px_ack
//     px_we     write(1) / read(0), stable while px_req is high
//     px_addr   byte address, stable while px_req is high
//     px_wdata  write data, stable while px_req is high
//     px_ack    one-cycle completion pulse
//     px_err    error flag, valid with px_ack
//     px_rdata  read data, updated on a read ack, held otherwise
//   Memory side:
//     Mem_Addr, M_W_Data, Mem_Read, Mem_Write  registered memory controls
//     M_R_Data                                 combinational read data
//   Status:
//     busy      high whenever the arbiter is not idle
//     grant_id  port currently or last served
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] M_W_Data;
    logic              Mem_Read;
    logic              Mem_Write;
    logic [DATA_W-1:0] M_R_Data;

    logic              busy;
    logic              grant_id;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  Mem_Addr, M_W_Data, Mem_Read, Mem_Write,
        output M_R_Data,
        input  busy, grant_id
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output Mem_Addr, M_W_Data, Mem_Read, Mem_Write,
        input  M_R_Data,
        output busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the data memory between port 0 (CPU load/store) and port 1
//   (debug/DMA loader). Round-robin arbitration in IDLE, one ACCESS cycle
//   with a single memory strobe, then one DONE cycle carrying the ack.
//   Request sampled in IDLE cycle N -> strobe in N+1 -> ack in N+2.
//
//   Ports:
//     CLK    clock, rising edge
//     Reset  asynchronous, active-high reset
//     bus    mem_arbiter_if.slave: both requester handshakes, memory pins,
//            busy and grant_id
//
//   Optional build macro MEM_ARB_ALIGN_CHK_EN: accesses with addr[1:0]!=0
//   or addr beyond MEM_BYTES-4 keep both strobes low, return rdata=0 and
//   raise err with the ack. Without it err is always 0 and every access is
//   issued to memory unchanged.
module mem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input logic          CLK,
    input logic          Reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              we_r;
    logic              err_r;

    logic              gnt_valid;
    logic              gnt_port;
    logic              gnt_we;
    logic              gnt_bad;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam logic [ADDR_W-1:0] MAX_WORD_ADDR = ADDR_W'(MEM_BYTES - 4);
`endif

    // Winner selection: on a tie, the port that was not served last wins.
    always_comb begin
        gnt_valid = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            gnt_port = ~last_grant;
        end else begin
            gnt_port = bus.p1_req;
        end
        gnt_we    = gnt_port ? bus.p1_we    : bus.p0_we;
        gnt_addr  = gnt_port ? bus.p1_addr  : bus.p0_addr;
        gnt_wdata = gnt_port ? bus.p1_wdata : bus.p0_wdata;
`ifdef MEM_ARB_ALIGN_CHK_EN
        gnt_bad   = (gnt_addr[1:0] != 2'b00) || (gnt_addr > MAX_WORD_ADDR);
`else
        gnt_bad   = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            we_r          <= 1'b0;
            err_r         <= 1'b0;
            bus.Mem_Addr  <= '0;
            bus.M_W_Data  <= '0;
            bus.Mem_Read  <= 1'b0;
            bus.Mem_Write <= 1'b0;
            bus.p0_ack    <= 1'b0;
            bus.p0_err    <= 1'b0;
            bus.p0_rdata  <= '0;
            bus.p1_ack    <= 1'b0;
            bus.p1_err    <= 1'b0;
            bus.p1_rdata  <= '0;
            bus.busy      <= 1'b0;
            bus.grant_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        bus.Mem_Addr  <= gnt_addr;
                        bus.M_W_Data  <= gnt_wdata;
                        we_r          <= gnt_we;
                        err_r         <= gnt_bad;
                        // Strobes are registered here so they are high
                        // for exactly the ACCESS cycle.
                        bus.Mem_Write <= gnt_we & ~gnt_bad;
                        bus.Mem_Read  <= ~gnt_we & ~gnt_bad;
                        bus.grant_id  <= gnt_port;
                        last_grant    <= gnt_port;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.Mem_Read  <= 1'b0;
                    bus.Mem_Write <= 1'b0;
                    if (!we_r || err_r) begin
                        if (bus.grant_id) begin
                            bus.p1_rdata <= err_r ? '0 : bus.M_R_Data;
                        end else begin
                            bus.p0_rdata <= err_r ? '0 : bus.M_R_Data;
                        end
                    end
                    bus.p0_ack <= ~bus.grant_id;
                    bus.p1_ack <= bus.grant_id;
                    bus.p0_err <= ~bus.grant_id & err_r;
                    bus.p1_err <= bus.grant_id & err_r;
                    state      <= DONE;
                end
                DONE: begin
                    bus.p0_ack <= 1'b0;
                    bus.p1_ack <= 1'b0;
                    bus.p0_err <= 1'b0;
                    bus.p1_err <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A byte-array memory answers the
//   memory pins; a transaction-level timeline model predicts every cycle's
//   strobes, acks, err, rdata, busy and grant_id. Directed vectors, a
//   fairness sequence, a mid-access reset and a random phase drive it.
module tb_mem_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int MAX_WORD = 28;

    logic CLK;
    logic Reset;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(32)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- memory attached to the arbiter ----------------
    logic [7:0] env_mem [64] = '{default: 8'h00};
    logic [5:0] ma;
    assign ma = bus.Mem_Addr;
    assign bus.M_R_Data = {env_mem[ma + 6'd3], env_mem[ma + 6'd2],
                           env_mem[ma + 6'd1], env_mem[ma]};
    always @(posedge CLK) begin
        if (bus.Mem_Write) begin
            env_mem[ma]        <= bus.M_W_Data[7:0];
            env_mem[ma + 6'd1] <= bus.M_W_Data[15:8];
            env_mem[ma + 6'd2] <= bus.M_W_Data[23:16];
            env_mem[ma + 6'd3] <= bus.M_W_Data[31:24];
        end
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  mref [64] = '{default: 8'h00};
    int          cyc       = 0;
    int          free_from = 0;
    int          acc_cyc   = -1;
    int          ack_cyc   = -1;
    int          last_grant = 1;
    int          grant_exp  = 0;
    int          acc_port   = 0;
    logic        acc_we, acc_err, rd_upd;
    logic [5:0]  acc_addr;
    logic [31:0] acc_wdata, rd_val;
    logic [31:0] rdata_exp [2];

    // requester state
    logic        pend   [2];
    logic        pwe    [2];
    logic [5:0]  paddr  [2];
    logic [31:0] pwdata [2];
    int          raise_pct = 0;
    logic [31:0] got_rdata;
    logic        got_err;
    int          ack_port_log [$];
    int          ack_cyc_log  [$];

    function automatic logic [31:0] mref_rd(logic [5:0] a);
        return {mref[a + 6'd3], mref[a + 6'd2], mref[a + 6'd1], mref[a]};
    endfunction

    task automatic drive();
        bus.p0_req   = pend[0];
        bus.p0_we    = pwe[0];
        bus.p0_addr  = paddr[0];
        bus.p0_wdata = pwdata[0];
        bus.p1_req   = pend[1];
        bus.p1_we    = pwe[1];
        bus.p1_addr  = paddr[1];
        bus.p1_wdata = pwdata[1];
    endtask

    task automatic new_req(int p, logic we, logic [5:0] addr, logic [31:0] wdata);
        pend[p]   = 1'b1;
        pwe[p]    = we;
        paddr[p]  = addr;
        pwdata[p] = wdata;
    endtask

    task automatic rand_req(int p);
        logic [5:0] a;
        if ($urandom_range(3) == 0) a = 6'($urandom_range(63));
        else                        a = 6'($urandom_range(7) * 4);
        new_req(p, 1'($urandom_range(1)), a, $urandom);
    endtask

    // Decide a grant for requests that the arbiter samples at the end of
    // the current cycle, and schedule its strobe and ack cycles.
    task automatic arbitrate();
        int p;
        if (cyc >= free_from && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) p = (last_grant == 0) ? 1 : 0;
            else                    p = pend[1] ? 1 : 0;
            acc_port  = p;
            acc_we    = pwe[p];
            acc_addr  = paddr[p];
            acc_wdata = pwdata[p];
`ifdef MEM_ARB_ALIGN_CHK_EN
            acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr > 6'(MAX_WORD));
`else
            acc_err = 1'b0;
`endif
            acc_cyc    = cyc + 1;
            ack_cyc    = cyc + 2;
            free_from  = cyc + 3;
            last_grant = p;
            grant_exp  = p;
            rd_upd     = 1'b0;
            if (acc_err) begin
                rd_upd = 1'b1;
                rd_val = '0;
            end else if (acc_we) begin
                mref[acc_addr]        = acc_wdata[7:0];
                mref[acc_addr + 6'd1] = acc_wdata[15:8];
                mref[acc_addr + 6'd2] = acc_wdata[23:16];
                mref[acc_addr + 6'd3] = acc_wdata[31:24];
            end else begin
                rd_upd = 1'b1;
                rd_val = mref_rd(acc_addr);
            end
        end
    endtask

    task automatic check_cycle();
        logic strobe;
        logic ack0, ack1;
        strobe = (cyc == acc_cyc) && !acc_err;
        ack0   = (cyc == ack_cyc) && (acc_port == 0);
        ack1   = (cyc == ack_cyc) && (acc_port == 1);
        if (cyc == ack_cyc && rd_upd) rdata_exp[acc_port] = rd_val;
        chk("mem_read",  32'(bus.Mem_Read),  32'(strobe && !acc_we));
        chk("mem_write", 32'(bus.Mem_Write), 32'(strobe && acc_we));
        if (strobe) chk("mem_addr", 32'(bus.Mem_Addr), 32'(acc_addr));
        if (strobe && acc_we) chk("m_w_data", bus.M_W_Data, acc_wdata);
        chk("p0_ack",   32'(bus.p0_ack), 32'(ack0));
        chk("p1_ack",   32'(bus.p1_ack), 32'(ack1));
        chk("p0_err",   32'(bus.p0_err), 32'(ack0 && acc_err));
        chk("p1_err",   32'(bus.p1_err), 32'(ack1 && acc_err));
        chk("p0_rdata", bus.p0_rdata, rdata_exp[0]);
        chk("p1_rdata", bus.p1_rdata, rdata_exp[1]);
        chk("busy",     32'(bus.busy), 32'(cyc == acc_cyc || cyc == ack_cyc));
        chk("grant_id", 32'(bus.grant_id), 32'(grant_exp));
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        check_cycle();
        if (bus.p0_ack) begin ack_port_log.push_back(0); ack_cyc_log.push_back(cyc); end
        if (bus.p1_ack) begin ack_port_log.push_back(1); ack_cyc_log.push_back(cyc); end
        if (cyc == ack_cyc) begin
            pend[acc_port] = 1'b0;
            got_rdata = (acc_port == 1) ? bus.p1_rdata : bus.p0_rdata;
            got_err   = (acc_port == 1) ? bus.p1_err   : bus.p0_err;
        end
        for (int p = 0; p < 2; p++)
            if (!pend[p] && $urandom_range(99) < raise_pct) rand_req(p);
        drive();
        arbitrate();
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive();
        acc_cyc      = -1;
        ack_cyc      = -1;
        last_grant   = 1;
        grant_exp    = 0;
        rdata_exp[0] = '0;
        rdata_exp[1] = '0;
        repeat (2) begin
            @(negedge CLK);
            cyc++;
            check_cycle();
        end
        Reset     = 1'b0;
        free_from = cyc;
    endtask

    task automatic drain();
        int n = 0;
        raise_pct = 0;
        while ((pend[0] || pend[1] || cyc < free_from) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 20), 32'(1));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          port;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam logic [31:0] RD02 = 32'h0000_0000;
    localparam logic [31:0] RD1E = 32'h0000_0000;
    localparam logic        BADE = 1'b1;
`else
    localparam logic [31:0] RD02 = 32'hBEEF_0000;
    localparam logic [31:0] RD1E = 32'h0000_1122;
    localparam logic        BADE = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{0, 1'b1, 6'h04, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{0, 1'b0, 6'h04, 32'h0,        32'hDEADBEEF,  1'b0};
        vecs[2] = '{1, 1'b1, 6'h1C, 32'h11223344, 32'h0000_0000, 1'b0};
        vecs[3] = '{0, 1'b0, 6'h1C, 32'h0,        32'h11223344,  1'b0};
        vecs[4] = '{1, 1'b0, 6'h04, 32'h0,        32'hDEADBEEF,  1'b0};
        vecs[5] = '{0, 1'b0, 6'h02, 32'h0,        RD02,          BADE};
        vecs[6] = '{1, 1'b0, 6'h1E, 32'h0,        RD1E,          BADE};
        vecs[7] = '{0, 1'b0, 6'h20, 32'h0,        32'h0000_0000, BADE};
        vecs[8] = '{1, 1'b0, 6'h1C, 32'h0,        32'h11223344,  1'b0};

        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwdata[p] = '0;
        end
        do_reset();

        for (int i = 0; i < 9; i++) begin
            new_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            drive();
            arbitrate();
            n = 0;
            while (pend[vecs[i].port] && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_ack_timeout", i), 32'(n < 20), 32'(1));
            chk($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
        end
        drain();

        // Both ports rise together after reset and keep requesting.
        do_reset();
        ack_port_log.delete();
        ack_cyc_log.delete();
        raise_pct = 100;
        rand_req(0);
        rand_req(1);
        drive();
        arbitrate();
        n = 0;
        while (ack_port_log.size() < 6 && n < 40) begin
            tick();
            n++;
        end
        drain();
        chk("rr_ack_count", 32'(ack_port_log.size() >= 6), 32'(1));
        if (ack_port_log.size() >= 6) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("rr_order%0d", i), 32'(ack_port_log[i]), 32'(i % 2));
            for (int i = 1; i < 6; i++)
                chk($sformatf("rr_spacing%0d", i),
                    32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'(3));
        end

        // Reset arriving while a read is in its ACCESS cycle.
        new_req(0, 1'b0, 6'h08, 32'h0);
        drive();
        arbitrate();
        n = 0;
        while (cyc != acc_cyc && n < 10) begin
            tick();
            n++;
        end
        chk("rst_reach_access", 32'(cyc == acc_cyc), 32'(1));
        Reset = 1'b1;
        #1;
        chk("rst_mem_read", 32'(bus.Mem_Read), 32'(0));
        chk("rst_busy",     32'(bus.busy),     32'(0));
        chk("rst_p0_ack",   32'(bus.p0_ack),   32'(0));
        do_reset();
        repeat (3) tick();
        ack_port_log.delete();
        ack_cyc_log.delete();
        new_req(0, 1'b0, 6'h04, 32'h0);
        new_req(1, 1'b0, 6'h1C, 32'h0);
        drive();
        arbitrate();
        n = 0;
        while (ack_port_log.size() < 1 && n < 10) begin
            tick();
            n++;
        end
        chk("rst_first_grant", 32'(ack_port_log.size() >= 1 ? ack_port_log[0] : 9), 32'(0));
        drain();

        // Random traffic against the model.
        raise_pct = 40;
        repeat (400) tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the 32-byte data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/DMA loader).
- Arbitrates round-robin, registers the winning request, drives the memory strobes for exactly one cycle, captures read data and returns a one-cycle ack.
- Sits between the requesters and the memory's Mem_Addr/M_W_Data/Mem_Read/Mem_Write/M_R_Data pins.

Parameters:
- ADDR_W, 6, byte address width.
- DATA_W, 32, word width.
- MEM_BYTES, 32, memory size in bytes; the highest legal word address is MEM_BYTES-4.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write(1)/read(0); stable while p0_req is high.
- p0_addr  in  ADDR_W  port 0 byte address; stable while p0_req is high.
- p0_wdata  in  DATA_W  port 0 write data; stable while p0_req is high.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  error flag, valid with p0_ack.
- p0_rdata  out  DATA_W  read data; updated on a port 0 read ack, held otherwise.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- Mem_Addr  out  ADDR_W  memory address (registered).
- M_W_Data  out  DATA_W  memory write data (registered).
- Mem_Read  out  1  memory read strobe.
- Mem_Write  out  1  memory write strobe.
- M_R_Data  in  DATA_W  memory read data; combinational from the memory.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  port currently or last served.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Both requests: grant the port != last_grant.
  - One request: grant that port.
  - On grant: latch addr, wdata and we into Mem_Addr, M_W_Data and an internal we register; set grant_id and last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - Mem_Write = we_r, Mem_Read = !we_r; never both high.
  - On a read, capture M_R_Data into the granted port's rdata register at the edge ending ACCESS.
  - Go to DONE.
- DONE (one cycle):
  - Granted port's ack=1; both strobes 0.
  - Next state: IDLE.
- Strobe timing: Mem_Read/Mem_Write are low in IDLE and DONE. Mem_Addr and M_W_Data hold their last values outside ACCESS.
- Latency: req sampled high in IDLE cycle N → strobe in cycle N+1 → ack in cycle N+2. Next grant no earlier than N+3.
- Handshake rules:
  - The requester drops or updates req at the edge ending its ack cycle, so a registered requester's req is already low in the following IDLE cycle.
  - A req still high in IDLE is a new request.
  - Changing addr, we or wdata while req is high before ack is illegal; behaviour is undefined.
- Simultaneous events: a new request arriving during ACCESS/DONE waits. The ungranted port is always served next if still requesting; no starvation, worst-case wait is 3 cycles.
- Writes: rdata of both ports unchanged; ack still pulses.
- Reset mid-operation: strobes and ack drop immediately (asynchronous); the FSM returns to IDLE; the in-flight access is dropped with no ack. The requester must reissue it; a write may or may not have reached memory.
- Widths: addresses are passed through unmodified, with no internal add; the memory performs the +1..+3 byte offsets.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHK_EN.
- Defined:
  - In IDLE, a granted request with addr[1:0]!=0 or addr>MEM_BYTES-4 (28) still moves to ACCESS, but both strobes stay 0.
  - rdata is loaded with 0, and the port's err=1 together with ack in DONE. Latency is unchanged.
  - Arbitration still rotates.
- Undefined:
  - p0_err/p1_err are tied 0 and every access is performed as issued.

Test Plan:
- Port 0 write 0xDEADBEEF @0x04, then read @0x04 → Mem_Write high one cycle (N+1); p0_ack at N+2; the read returns p0_rdata=0xDEADBEEF; p1_ack stays 0.
- p0_req and p1_req rise in the same cycle after reset → port 0 served first (grant_id=0), port 1 next. Ack cycles are exactly 3 apart.
- Both ports requesting continuously for 6 transactions → grants alternate 0,1,0,1,0,1; no two strobes within 3 cycles of each other.
- Port 1 write 0x11223344 @0x1C, then port 0 read @0x1C → p0_rdata=0x11223344; p1_rdata unchanged.
- Reset asserted during ACCESS of a read → Mem_Read and busy fall immediately; no ack; after release the first grant goes to port 0 again.
- With MEM_ARB_ALIGN_CHK_EN: read @0x02 and @0x1E → no strobes; ack with err=1 and rdata=0. Without the macro: read @0x02 → Mem_Read pulses and err=0.
